reorder_buffer: RTL and testbench

// 16-entry, 2-wide reorder buffer: the receiving end of the reservation station's ROB dispatch interface.

---
 rtl/reorder_buffer.sv | 204 ++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// 16-entry, 2-wide reorder buffer.
// Takes dispatches at chosen indices, records completions, retires in order.
module reorder_buffer #(
  parameter int NUM_ENTRIES = 16,
  parameter int IDXW        = 4,
  parameter int PREG_W      = 6,
  parameter int PC_W        = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     disp_valid1,
  input  logic [IDXW-1:0]          disp_robNum1,
  input  logic [PREG_W-1:0]        disp_destReg1,
  input  logic [PREG_W-1:0]        disp_destRegOld1,
  input  logic [PC_W-1:0]          disp_pc1,
  input  logic                     disp_valid2,
  input  logic [IDXW-1:0]          disp_robNum2,
  input  logic [PREG_W-1:0]        disp_destReg2,
  input  logic [PREG_W-1:0]        disp_destRegOld2,
  input  logic [PC_W-1:0]          disp_pc2,
  input  logic                     cmp_valid1,
  input  logic [IDXW-1:0]          cmp_robNum1,
  input  logic                     cmp_valid2,
  input  logic [IDXW-1:0]          cmp_robNum2,
  output logic [NUM_ENTRIES-1:0]   robFree,
  output logic                     retire_valid1,
  output logic [PREG_W-1:0]        retire_destReg1,
  output logic [PREG_W-1:0]        retire_freeReg1,
  output logic [PC_W-1:0]          retire_pc1,
  output logic                     retire_valid2,
  output logic [PREG_W-1:0]        retire_destReg2,
  output logic [PREG_W-1:0]        retire_freeReg2,
  output logic [PC_W-1:0]          retire_pc2,
  output logic [(1<<PREG_W)-1:0]   retireRegReady,
  output logic [IDXW:0]            rob_count,
  output logic                     rob_err
);

  localparam int NREG = 1 << PREG_W;
  localparam int CNTW = IDXW + 1;
  localparam logic [IDXW-1:0] IDX_ONE = 1;
  localparam logic [NREG-1:0] REG_ONE = 1;

  logic [NUM_ENTRIES-1:0] busy_q, busy_d;
  logic [NUM_ENTRIES-1:0] done_q, done_d;
  logic [NUM_ENTRIES-1:0] free_q, free_d;
  logic [PREG_W-1:0]      dest_q [NUM_ENTRIES];
  logic [PREG_W-1:0]      dest_d [NUM_ENTRIES];
  logic [PREG_W-1:0]      old_q  [NUM_ENTRIES];
  logic [PREG_W-1:0]      old_d  [NUM_ENTRIES];
  logic [PC_W-1:0]        pc_q   [NUM_ENTRIES];
  logic [PC_W-1:0]        pc_d   [NUM_ENTRIES];
  logic [IDXW-1:0]        queue_q [NUM_ENTRIES];
  logic [IDXW-1:0]        queue_d [NUM_ENTRIES];
  logic [IDXW-1:0]        head_q, head_d;
  logic [IDXW-1:0]        tail_q, tail_d;
  logic [CNTW-1:0]        count_q, count_d;
  logic                   err_q, err_d;

  logic                   rv1_q, rv1_d, rv2_q, rv2_d;
  logic [PREG_W-1:0]      rd1_q, rd1_d, rd2_q, rd2_d;
  logic [PREG_W-1:0]      rf1_q, rf1_d, rf2_q, rf2_d;
  logic [PC_W-1:0]        rp1_q, rp1_d, rp2_q, rp2_d;
  logic [NREG-1:0]        rr_q, rr_d;

  logic [IDXW-1:0]        h0, h1;
  logic                   r0, r1;
  logic                   a1, a2;
  logic                   disp_bad, cmp_bad;
  logic [1:0]             n_acc, n_ret;

  // Accept, complete and retire decisions, all from pre-edge state
  always_comb begin
    h0       = queue_q[head_q];
    h1       = queue_q[head_q + IDX_ONE];
    r0       = (count_q != '0) && done_q[h0];
    r1       = r0 && (count_q[CNTW-1:1] != '0) && done_q[h1];
    a1       = disp_valid1 && !busy_q[disp_robNum1];
    a2       = disp_valid2 && !busy_q[disp_robNum2]
               && !(disp_valid1 && (disp_robNum1 == disp_robNum2));
    disp_bad = (disp_valid1 && !a1) || (disp_valid2 && !a2);
    cmp_bad  = (cmp_valid1 && !busy_q[cmp_robNum1])
               || (cmp_valid2 && !busy_q[cmp_robNum2]);
    n_acc    = {1'b0, a1} + {1'b0, a2};
    n_ret    = {1'b0, r0} + {1'b0, r1};
  end

  // Next-state for entries, order queue, pointers and retire outputs
  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    dest_d  = dest_q;
    old_d   = old_q;
    pc_d    = pc_q;
    queue_d = queue_q;

    if (cmp_valid1 && busy_q[cmp_robNum1]) done_d[cmp_robNum1] = 1'b1;
    if (cmp_valid2 && busy_q[cmp_robNum2]) done_d[cmp_robNum2] = 1'b1;

    if (r0) begin
      busy_d[h0] = 1'b0;
      done_d[h0] = 1'b0;
    end
    if (r1) begin
      busy_d[h1] = 1'b0;
      done_d[h1] = 1'b0;
    end

    if (a1) begin
      busy_d[disp_robNum1] = 1'b1;
      done_d[disp_robNum1] = 1'b0;
      dest_d[disp_robNum1] = disp_destReg1;
      old_d[disp_robNum1]  = disp_destRegOld1;
      pc_d[disp_robNum1]   = disp_pc1;
      queue_d[tail_q]      = disp_robNum1;
    end
    if (a2) begin
      busy_d[disp_robNum2] = 1'b1;
      done_d[disp_robNum2] = 1'b0;
      dest_d[disp_robNum2] = disp_destReg2;
      old_d[disp_robNum2]  = disp_destRegOld2;
      pc_d[disp_robNum2]   = disp_pc2;
      queue_d[a1 ? tail_q + IDX_ONE : tail_q] = disp_robNum2;
    end

    free_d  = ~busy_d;
    head_d  = head_q + IDXW'(n_ret);
    tail_d  = tail_q + IDXW'(n_acc);
    count_d = count_q + CNTW'(n_acc) - CNTW'(n_ret);
    err_d   = err_q || disp_bad || cmp_bad;

    rv1_d = r0;
    rd1_d = r0 ? dest_q[h0] : '0;
    rf1_d = r0 ? old_q[h0]  : '0;
    rp1_d = r0 ? pc_q[h0]   : '0;
    rv2_d = r1;
    rd2_d = r1 ? dest_q[h1] : '0;
    rf2_d = r1 ? old_q[h1]  : '0;
    rp2_d = r1 ? pc_q[h1]   : '0;
    rr_d  = (r0 ? REG_ONE << dest_q[h0] : '0)
          | (r1 ? REG_ONE << dest_q[h1] : '0);
  end

  // Control state and registered outputs, reset to empty
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= '0;
      done_q  <= '0;
      free_q  <= '1;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd1_q   <= '0;
      rf1_q   <= '0;
      rp1_q   <= '0;
      rv2_q   <= 1'b0;
      rd2_q   <= '0;
      rf2_q   <= '0;
      rp2_q   <= '0;
      rr_q    <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      free_q  <= free_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
      rv1_q   <= rv1_d;
      rd1_q   <= rd1_d;
      rf1_q   <= rf1_d;
      rp1_q   <= rp1_d;
      rv2_q   <= rv2_d;
      rd2_q   <= rd2_d;
      rf2_q   <= rf2_d;
      rp2_q   <= rp2_d;
      rr_q    <= rr_d;
    end
  end

  // Payload storage; only read under busy, so no reset needed
  always_ff @(posedge clk) begin
    dest_q  <= dest_d;
    old_q   <= old_d;
    pc_q    <= pc_d;
    queue_q <= queue_d;
  end

  assign robFree         = free_q;
  assign rob_count       = count_q;
  assign rob_err         = err_q;
  assign retire_valid1   = rv1_q;
  assign retire_destReg1 = rd1_q;
  assign retire_freeReg1 = rf1_q;
  assign retire_pc1      = rp1_q;
  assign retire_valid2   = rv2_q;
  assign retire_destReg2 = rd2_q;
  assign retire_freeReg2 = rf2_q;
  assign retire_pc2      = rp2_q;
  assign retireRegReady  = rr_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: vector table, corner sequences,
// and a scoreboard for in-order retirement over wrap-around.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_valid1, disp_valid2;
  logic [3:0]  disp_robNum1, disp_robNum2;
  logic [5:0]  disp_destReg1, disp_destReg2;
  logic [5:0]  disp_destRegOld1, disp_destRegOld2;
  logic [31:0] disp_pc1, disp_pc2;
  logic        cmp_valid1, cmp_valid2;
  logic [3:0]  cmp_robNum1, cmp_robNum2;
  logic [15:0] robFree;
  logic        retire_valid1, retire_valid2;
  logic [5:0]  retire_destReg1, retire_destReg2;
  logic [5:0]  retire_freeReg1, retire_freeReg2;
  logic [31:0] retire_pc1, retire_pc2;
  logic [63:0] retireRegReady;
  logic [4:0]  rob_count;
  logic        rob_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .reset(reset),
    .disp_valid1(disp_valid1), .disp_robNum1(disp_robNum1),
    .disp_destReg1(disp_destReg1), .disp_destRegOld1(disp_destRegOld1),
    .disp_pc1(disp_pc1),
    .disp_valid2(disp_valid2), .disp_robNum2(disp_robNum2),
    .disp_destReg2(disp_destReg2), .disp_destRegOld2(disp_destRegOld2),
    .disp_pc2(disp_pc2),
    .cmp_valid1(cmp_valid1), .cmp_robNum1(cmp_robNum1),
    .cmp_valid2(cmp_valid2), .cmp_robNum2(cmp_robNum2),
    .robFree(robFree),
    .retire_valid1(retire_valid1), .retire_destReg1(retire_destReg1),
    .retire_freeReg1(retire_freeReg1), .retire_pc1(retire_pc1),
    .retire_valid2(retire_valid2), .retire_destReg2(retire_destReg2),
    .retire_freeReg2(retire_freeReg2), .retire_pc2(retire_pc2),
    .retireRegReady(retireRegReady),
    .rob_count(rob_count), .rob_err(rob_err)
  );

  typedef struct {
    logic v1; logic [3:0] n1; logic [5:0] d1;
    logic v2; logic [3:0] n2; logic [5:0] d2;
    logic c1v; logic [3:0] c1n; logic c2v; logic [3:0] c2n;
    logic [15:0] free; logic [4:0] cnt; logic err;
    logic rv1; logic [5:0] rd1; logic rv2; logic [5:0] rd2;
    logic [63:0] rr;
  } vec_t;

  typedef struct {
    logic [3:0] idx; logic [5:0] d; logic [31:0] pc;
  } sb_t;

  vec_t vt [14];
  sb_t  sbq [$];
  logic [15:0] tb_busy, tb_done;

  function automatic logic [5:0] old_of(logic [5:0] d);
    return d ^ 6'h2A;
  endfunction

  function automatic logic [31:0] pc_of(logic [5:0] d);
    return 32'h0000_1000 + {24'h0, d, 2'b00};
  endfunction

  function automatic int pick(logic [15:0] m);
    int n = 0;
    int k;
    for (int i = 0; i < 16; i++) if (m[i]) n++;
    if (n == 0) return -1;
    k = $urandom_range(0, n - 1);
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        if (k == 0) return i;
        k--;
      end
    end
    return -1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    disp_valid1 = 0; disp_robNum1 = 0; disp_destReg1 = 0;
    disp_destRegOld1 = 0; disp_pc1 = 0;
    disp_valid2 = 0; disp_robNum2 = 0; disp_destReg2 = 0;
    disp_destRegOld2 = 0; disp_pc2 = 0;
    cmp_valid1 = 0; cmp_robNum1 = 0;
    cmp_valid2 = 0; cmp_robNum2 = 0;
  endtask

  task automatic d1(logic [3:0] n, logic [5:0] d, logic [31:0] pc);
    disp_valid1 = 1; disp_robNum1 = n; disp_destReg1 = d;
    disp_destRegOld1 = old_of(d); disp_pc1 = pc;
  endtask

  task automatic d2(logic [3:0] n, logic [5:0] d, logic [31:0] pc);
    disp_valid2 = 1; disp_robNum2 = n; disp_destReg2 = d;
    disp_destRegOld2 = old_of(d); disp_pc2 = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic sb_pop(logic [5:0] d, logic [5:0] f, logic [31:0] pc);
    sb_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL sb_underflow act=retire exp=none");
    end else begin
      e = sbq.pop_front();
      chk("sb_dest", d, e.d);
      chk("sb_free", f, old_of(e.d));
      chk("sb_pc", pc, e.pc);
      tb_busy[e.idx] = 0;
      tb_done[e.idx] = 0;
    end
  endtask

  initial begin
    reset = 1;
    clear_in();

    vt[0]  = '{1'b1,4'd15,6'd5, 1'b1,4'd14,6'd9, 1'b0,4'd0,1'b0,4'd0,
               16'h3FFF,5'd2,1'b0, 1'b0,6'd0,1'b0,6'd0, 64'h0};
    vt[1]  = '{1'b0,4'd0,6'd0, 1'b0,4'd0,6'd0, 1'b1,4'd14,1'b0,4'd0,
               16'h3FFF,5'd2,1'b0, 1'b0,6'd0,1'b0,6'd0, 64'h0};
    vt[2]  = '{1'b0,4'd0,6'd0, 1'b0,4'd0,6'd0, 1'b1,4'd15,1'b0,4'd0,
               16'h3FFF,5'd2,1'b0, 1'b0,6'd0,1'b0,6'd0, 64'h0};
    vt[3]  = '{1'b0,4'd0,6'd0, 1'b0,4'd0,6'd0, 1'b0,4'd0,1'b0,4'd0,
               16'hFFFF,5'd0,1'b0, 1'b1,6'd5,1'b1,6'd9, 64'h220};
    vt[4]  = '{1'b0,4'd0,6'd0, 1'b0,4'd0,6'd0, 1'b0,4'd0,1'b0,4'd0,
               16'hFFFF,5'd0,1'b0, 1'b0,6'd0,1'b0,6'd0, 64'h0};
    vt[5]  = '{1'b0,4'd0,6'd0, 1'b1,4'd7,6'd11, 1'b0,4'd0,1'b0,4'd0,
               16'hFF7F,5'd1,1'b0, 1'b0,6'd0,1'b0,6'd0, 64'h0};
    vt[6]  = '{1'b1,4'd0,6'd12, 1'b0,4'd0,6'd0, 1'b1,4'd7,1'b0,4'd0,
               16'hFF7E,5'd2,1'b0, 1'b0,6'd0,1'b0,6'd0, 64'h0};
    vt[7]  = '{1'b1,4'd1,6'd13, 1'b0,4'd0,6'd0, 1'b0,4'd0,1'b1,4'd0,
               16'hFFFC,5'd2,1'b0, 1'b1,6'd11,1'b0,6'd0, 64'h800};
    vt[8]  = '{1'b0,4'd0,6'd0, 1'b0,4'd0,6'd0, 1'b0,4'd0,1'b0,4'd0,
               16'hFFFD,5'd1,1'b0, 1'b1,6'd12,1'b0,6'd0, 64'h1000};
    vt[9]  = '{1'b0,4'd0,6'd0, 1'b0,4'd0,6'd0, 1'b1,4'd1,1'b1,4'd1,
               16'hFFFD,5'd1,1'b0, 1'b0,6'd0,1'b0,6'd0, 64'h0};
    vt[10] = '{1'b0,4'd0,6'd0, 1'b0,4'd0,6'd0, 1'b0,4'd0,1'b0,4'd0,
               16'hFFFF,5'd0,1'b0, 1'b1,6'd13,1'b0,6'd0, 64'h2000};
    vt[11] = '{1'b1,4'd3,6'd20, 1'b1,4'd3,6'd21, 1'b0,4'd0,1'b0,4'd0,
               16'hFFF7,5'd1,1'b1, 1'b0,6'd0,1'b0,6'd0, 64'h0};
    vt[12] = '{1'b0,4'd0,6'd0, 1'b0,4'd0,6'd0, 1'b1,4'd3,1'b0,4'd0,
               16'hFFF7,5'd1,1'b1, 1'b0,6'd0,1'b0,6'd0, 64'h0};
    vt[13] = '{1'b0,4'd0,6'd0, 1'b0,4'd0,6'd0, 1'b0,4'd0,1'b0,4'd0,
               16'hFFFF,5'd0,1'b1, 1'b1,6'd20,1'b0,6'd0, 64'h100000};

    do_reset();
    chk("rst_free", robFree, 16'hFFFF);
    chk("rst_count", rob_count, 0);
    chk("rst_err", rob_err, 0);
    step();
    chk("idle_rv1", retire_valid1, 0);
    chk("idle_rv2", retire_valid2, 0);
    chk("idle_rr", retireRegReady, 0);

    for (int i = 0; i < 14; i++) begin
      clear_in();
      if (vt[i].v1) d1(vt[i].n1, vt[i].d1, pc_of(vt[i].d1));
      if (vt[i].v2) d2(vt[i].n2, vt[i].d2, pc_of(vt[i].d2));
      cmp_valid1 = vt[i].c1v; cmp_robNum1 = vt[i].c1n;
      cmp_valid2 = vt[i].c2v; cmp_robNum2 = vt[i].c2n;
      step();
      chk($sformatf("v%0d_free", i), robFree, vt[i].free);
      chk($sformatf("v%0d_cnt", i), rob_count, vt[i].cnt);
      chk($sformatf("v%0d_err", i), rob_err, vt[i].err);
      chk($sformatf("v%0d_rv1", i), retire_valid1, vt[i].rv1);
      chk($sformatf("v%0d_rd1", i), retire_destReg1, vt[i].rd1);
      chk($sformatf("v%0d_rf1", i), retire_freeReg1,
          vt[i].rv1 ? old_of(vt[i].rd1) : 6'd0);
      chk($sformatf("v%0d_rp1", i), retire_pc1,
          vt[i].rv1 ? pc_of(vt[i].rd1) : 32'd0);
      chk($sformatf("v%0d_rv2", i), retire_valid2, vt[i].rv2);
      chk($sformatf("v%0d_rd2", i), retire_destReg2, vt[i].rd2);
      chk($sformatf("v%0d_rf2", i), retire_freeReg2,
          vt[i].rv2 ? old_of(vt[i].rd2) : 6'd0);
      chk($sformatf("v%0d_rp2", i), retire_pc2,
          vt[i].rv2 ? pc_of(vt[i].rd2) : 32'd0);
      chk($sformatf("v%0d_rr", i), retireRegReady, vt[i].rr);
    end

    // Fill all 16, then a 17th dispatch is dropped
    do_reset();
    for (int i = 0; i < 8; i++) begin
      clear_in();
      d1(4'(2 * i), 6'(2 * i), 32'h0);
      d2(4'(2 * i + 1), 6'(2 * i + 1), 32'h0);
      step();
    end
    chk("full_free", robFree, 16'h0);
    chk("full_cnt", rob_count, 16);
    chk("full_err0", rob_err, 0);
    clear_in();
    d1(4'd0, 6'd40, 32'h0);
    step();
    chk("full_cnt17", rob_count, 16);
    chk("full_err1", rob_err, 1);
    chk("full_free17", robFree, 16'h0);

    // Completion to a non-busy entry
    do_reset();
    cmp_valid1 = 1; cmp_robNum1 = 5;
    step();
    chk("cmp_idle_err", rob_err, 1);
    chk("cmp_idle_cnt", rob_count, 0);

    // Completion on the same edge as its dispatch is ignored
    do_reset();
    d1(4'd2, 6'd30, 32'h0);
    cmp_valid1 = 1; cmp_robNum1 = 2;
    step();
    chk("dc_err", rob_err, 1);
    chk("dc_cnt", rob_count, 1);
    clear_in();
    step();
    chk("dc_noret", retire_valid1, 0);

    // Re-dispatch into an entry retiring at the same edge
    do_reset();
    d1(4'd4, 6'd7, 32'h0);
    step();
    clear_in();
    cmp_valid1 = 1; cmp_robNum1 = 4;
    step();
    clear_in();
    d1(4'd4, 6'd8, 32'h0);
    step();
    chk("rd_rv1", retire_valid1, 1);
    chk("rd_dest", retire_destReg1, 7);
    chk("rd_err", rob_err, 1);
    chk("rd_cnt", rob_count, 0);
    chk("rd_free", robFree, 16'hFFFF);

    // Reset while 6 entries are busy, with a dispatch on the same edge
    do_reset();
    for (int i = 0; i < 3; i++) begin
      clear_in();
      d1(4'(2 * i + 8), 6'(i), 32'h0);
      d2(4'(2 * i + 9), 6'(i + 8), 32'h0);
      step();
    end
    chk("r6_cnt_pre", rob_count, 6);
    clear_in();
    d1(4'd1, 6'd1, 32'h0);
    reset = 1;
    step();
    reset = 0;
    clear_in();
    chk("r6_free", robFree, 16'hFFFF);
    chk("r6_cnt", rob_count, 0);
    chk("r6_err", rob_err, 0);
    chk("r6_rv1", retire_valid1, 0);
    chk("r6_rr", retireRegReady, 0);
    step();
    chk("r6_rv1b", retire_valid1, 0);

    // Scoreboard: 20 dispatches, random completion order
    begin
      int  ndisp;
      bit  sb_done;
      ndisp   = 0;
      sb_done = 0;
      tb_busy = '0;
      tb_done = '0;
      do_reset();
      for (int cyc = 0; cyc < 400 && !sb_done; cyc++) begin
        logic [15:0] fm, cm;
        int i1, i2, c1, c2, r;
        sb_t e;
        clear_in();
        fm = ~tb_busy;
        i1 = -1; i2 = -1; c1 = -1; c2 = -1;
        r  = $urandom_range(0, 3);
        if (r[0] && ndisp < 20) i1 = pick(fm);
        if (i1 >= 0) begin
          fm[i1] = 0;
          e.idx = 4'(i1);
          e.d   = 6'($urandom_range(0, 63));
          e.pc  = $urandom;
          d1(e.idx, e.d, e.pc);
          sbq.push_back(e);
          ndisp++;
        end
        if (r[1] && ndisp < 20) i2 = pick(fm);
        if (i2 >= 0) begin
          e.idx = 4'(i2);
          e.d   = 6'($urandom_range(0, 63));
          e.pc  = $urandom;
          d2(e.idx, e.d, e.pc);
          sbq.push_back(e);
          ndisp++;
        end
        cm = tb_busy & ~tb_done;
        if ($urandom_range(0, 1) == 1) c1 = pick(cm);
        if ($urandom_range(0, 1) == 1) c2 = pick(cm);
        if (c1 >= 0) begin
          cmp_valid1 = 1; cmp_robNum1 = 4'(c1);
        end
        if (c2 >= 0) begin
          cmp_valid2 = 1; cmp_robNum2 = 4'(c2);
        end
        step();
        if (i1 >= 0) tb_busy[i1] = 1;
        if (i2 >= 0) tb_busy[i2] = 1;
        if (c1 >= 0) tb_done[c1] = 1;
        if (c2 >= 0) tb_done[c2] = 1;
        chk("sb_inorder", retire_valid2 & ~retire_valid1, 0);
        if (retire_valid1)
          sb_pop(retire_destReg1, retire_freeReg1, retire_pc1);
        if (retire_valid2)
          sb_pop(retire_destReg2, retire_freeReg2, retire_pc2);
        sb_done = (ndisp == 20) && (sbq.size() == 0);
      end
      chk("sb_finished", sb_done, 1);
      chk("sb_err", rob_err, 0);
      chk("sb_cnt", rob_count, 0);
      chk("sb_free", robFree, 16'hFFFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
